// File: rtl/rr_bus_arbiter.sv
// Bus arbiter granting one of NUM_REQ masters, round-robin or fixed priority,
// with optional locked bursts and a watchdog that forces a stuck owner off the bus.
module rr_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MODE      = 0,
    parameter int TIMEOUT   = 0,
    parameter int MAX_BURST = 0,
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout_err
);

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic               owner_req;
    logic               owner_lock;
    logic               tmo_hit;
    logic               burst_ok;
    logic               keep;
    logic               rel;
    logic               take;
    logic               drop;
    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   start;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    always_comb begin
        owner_req  = |(req & grant);
        owner_lock = |(lock & grant);
        tmo_hit    = (TIMEOUT > 0) && (state == StBusy) &&
                     (tmo_cnt == CNT_W'(TIMEOUT - 1)) && !done;
        burst_ok   = (MAX_BURST == 0) || (burst_cnt < BURST_W'(MAX_BURST));
        keep       = (state == StBusy) && done && owner_req && owner_lock && burst_ok;
        rel        = (state == StBusy) &&
                     (tmo_hit || (done && !keep) || (!done && !owner_req));
        // A timed-out owner may not win the arbitration that removes it.
        elig       = tmo_hit ? (req & ~grant) : req;
        if (MODE == 1 || last_idx == IDX_W'(NUM_REQ - 1)) begin
            start = '0;
        end else begin
            start = last_idx + 1'b1;
        end
    end

    // Two passes: indices at or above start first, then wrap to the bottom.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && elig[i] && (IDX_W'(i) >= start)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && elig[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        win_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << win_idx;
        take       = win_found && ((state == StIdle) || rel);
        drop       = rel && !win_found;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            last_idx    <= IDX_W'(NUM_REQ - 1);
            tmo_cnt     <= '0;
            burst_cnt   <= '0;
        end else begin
            timeout_err <= tmo_hit;
            if (take) begin
                state       <= StBusy;
                grant       <= win_onehot;
                grant_idx   <= win_idx;
                grant_valid <= 1'b1;
                last_idx    <= win_idx;
                tmo_cnt     <= '0;
                burst_cnt   <= '0;
            end else if (drop) begin
                state       <= StIdle;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
                tmo_cnt     <= '0;
                burst_cnt   <= '0;
            end else if (state == StBusy) begin
                if (keep) begin
                    tmo_cnt <= '0;
                    if (burst_cnt != '1) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else if (TIMEOUT > 0 && tmo_cnt != '1) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
